// File: rtl/bomber_pkg.sv
// Shared types for the bomber player controller: cell coordinates, FSM states
// and the decoded movement direction.
package bomber_pkg;

    localparam int COORD_W = 4;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_HOLD
    } state_t;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer: the stable level follows the raw key only after
// DEB_CYCLES consecutive raw samples that disagree with it.
module key_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Down-counter runs while raw differs from stable; terminal count flips stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= 1'b0;
            cnt    <= RELOAD;
        end else if (raw == stable) begin
            cnt <= RELOAD;
        end else if (cnt == '0) begin
            stable <= raw;
            cnt    <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/bomber_player_ctrl.sv
// Player movement and bomb-placement controller for a grid playfield.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no direction being acted on; waits for a debounced key
//   S_CHECK | one cycle: target cell presented on the wall query port
//   S_HOLD  | key still held; down-counter times the next auto-repeat
module bomber_player_ctrl
    import bomber_pkg::*;
#(
    parameter int GRID_W     = 15,
    parameter int GRID_H     = 13,
    parameter int START_X    = 1,
    parameter int START_Y    = 1,
    parameter int DEB_CYCLES = 4,
    parameter int REPEAT_DLY = 8,
    parameter int REPEAT_PER = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               up,
    input  logic               down,
    input  logic               left,
    input  logic               right,
    input  logic               action,
    output logic [COORD_W-1:0] query_x,
    output logic [COORD_W-1:0] query_y,
    output logic               query_valid,
    input  logic               query_wall,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               moved,
    output logic               bomb_req,
    input  logic               bomb_ack,
    output logic [COORD_W-1:0] bomb_x,
    output logic [COORD_W-1:0] bomb_y
);

    localparam int HMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int HCW  = $clog2(HMAX + 1);
    localparam logic [HCW-1:0] LOAD_DLY = HCW'(REPEAT_DLY);
    localparam logic [HCW-1:0] LOAD_PER = HCW'(REPEAT_PER);
    // Leaving S_HOLD at 2 absorbs the HOLD->CHECK and CHECK->move edges, so
    // consecutive moved pulses are exactly REPEAT_DLY / REPEAT_PER apart.
    localparam logic [HCW-1:0] HOLD_TC  = HCW'(2);

    logic [4:0] keys_raw;
    logic [4:0] keys;

    assign keys_raw = {action, right, left, down, up};

    for (genvar i = 0; i < 5; i++) begin : g_deb
        key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk    (clk),
            .rst    (rst),
            .raw    (keys_raw[i]),
            .stable (keys[i])
        );
    end

    state_t         state;
    dir_t           dir;
    dir_t           hold_dir;
    logic [HCW-1:0] hold_cnt;
    logic           rep;
    coord_t         tgt_x;
    coord_t         tgt_y;
    logic           tgt_in;
    logic           act_prev;

    // Fixed-priority direction pick: up > down > left > right.
    always_comb begin
        dir = DIR_NONE;
        if (keys[0])      dir = DIR_UP;
        else if (keys[1]) dir = DIR_DOWN;
        else if (keys[2]) dir = DIR_LEFT;
        else if (keys[3]) dir = DIR_RIGHT;
    end

    // Neighbouring cell in the active direction and whether it is on the grid.
    always_comb begin
        tgt_x  = pos_x;
        tgt_y  = pos_y;
        tgt_in = 1'b0;
        case (dir)
            DIR_UP: begin
                tgt_y  = pos_y - 1'b1;
                tgt_in = (pos_y != '0);
            end
            DIR_DOWN: begin
                tgt_y  = pos_y + 1'b1;
                tgt_in = (pos_y != coord_t'(GRID_H - 1));
            end
            DIR_LEFT: begin
                tgt_x  = pos_x - 1'b1;
                tgt_in = (pos_x != '0);
            end
            DIR_RIGHT: begin
                tgt_x  = pos_x + 1'b1;
                tgt_in = (pos_x != coord_t'(GRID_W - 1));
            end
            default: ;
        endcase
    end

    // Movement FSM with registered query, position and moved outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pos_x       <= coord_t'(START_X);
            pos_y       <= coord_t'(START_Y);
            moved       <= 1'b0;
            query_valid <= 1'b0;
            query_x     <= '0;
            query_y     <= '0;
            hold_cnt    <= '0;
            hold_dir    <= DIR_NONE;
            rep         <= 1'b0;
        end else begin
            moved       <= 1'b0;
            query_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (dir != DIR_NONE) begin
                        hold_dir <= dir;
                        if (tgt_in) begin
                            state       <= S_CHECK;
                            query_valid <= 1'b1;
                            query_x     <= tgt_x;
                            query_y     <= tgt_y;
                            rep         <= 1'b0;
                        end else begin
                            state    <= S_HOLD;
                            hold_cnt <= LOAD_DLY;
                        end
                    end
                end
                S_CHECK: begin
                    if (!query_wall) begin
                        pos_x <= query_x;
                        pos_y <= query_y;
                        moved <= 1'b1;
                    end
                    state    <= S_HOLD;
                    hold_cnt <= rep ? LOAD_PER : LOAD_DLY;
                end
                S_HOLD: begin
                    if (dir != hold_dir) begin
                        state <= S_IDLE;
                    end else if (hold_cnt <= HOLD_TC) begin
                        if (tgt_in) begin
                            state       <= S_CHECK;
                            query_valid <= 1'b1;
                            query_x     <= tgt_x;
                            query_y     <= tgt_y;
                            rep         <= 1'b1;
                        end else begin
                            hold_cnt <= LOAD_PER;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bomb request: captured on a debounced action edge, held until acked.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_prev <= 1'b0;
            bomb_req <= 1'b0;
            bomb_x   <= '0;
            bomb_y   <= '0;
        end else begin
            act_prev <= keys[4];
            if (!bomb_req) begin
                if (keys[4] && !act_prev) begin
                    bomb_req <= 1'b1;
                    bomb_x   <= pos_x;
                    bomb_y   <= pos_y;
                end
            end else if (bomb_ack) begin
                bomb_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bomber_player_ctrl.sv
// Scoreboard bench for bomber_player_ctrl: stimulus pushes expected queries,
// moves, bombs and status snapshots; the monitor pops and compares them.
module tb_bomber_player_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, action = 1'b0;
    logic [3:0] query_x, query_y, pos_x, pos_y, bomb_x, bomb_y;
    logic       query_valid, moved, bomb_req;
    logic       query_wall = 1'b0;
    logic       bomb_ack = 1'b0;

    bomber_player_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .up          (up),
        .down        (down),
        .left        (left),
        .right       (right),
        .action      (action),
        .query_x     (query_x),
        .query_y     (query_y),
        .query_valid (query_valid),
        .query_wall  (query_wall),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .moved       (moved),
        .bomb_req    (bomb_req),
        .bomb_ack    (bomb_ack),
        .bomb_x      (bomb_x),
        .bomb_y      (bomb_y)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int gap; } xy_t;
    typedef struct {
        string name;
        int    px, py, mv, qv, breq, bx, by;
        bit    empty;
        bit    tmo;
    } st_t;

    xy_t q_exp[$];
    xy_t m_exp[$];
    xy_t b_exp[$];
    st_t st_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_mv = 0;
    int mv_seen = 0;
    int qv_seen = 0;
    logic bomb_prev = 1'b0;

    function automatic void cmp(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clk) begin
        xy_t e;
        st_t s;
        cyc++;
        if (!rst) begin
            if (query_valid) begin
                qv_seen++;
                if (q_exp.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_query: got (%0d,%0d) want none", query_x, query_y);
                end else begin
                    e = q_exp.pop_front();
                    cmp("query_x", int'(query_x), e.x);
                    cmp("query_y", int'(query_y), e.y);
                end
            end
            if (moved) begin
                mv_seen++;
                if (m_exp.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_move: got (%0d,%0d) want none", pos_x, pos_y);
                end else begin
                    e = m_exp.pop_front();
                    cmp("move_x", int'(pos_x), e.x);
                    cmp("move_y", int'(pos_y), e.y);
                    if (e.gap != 0) cmp("move_gap", cyc - last_mv, e.gap);
                end
                last_mv = cyc;
            end
            if (bomb_req && !bomb_prev) begin
                if (b_exp.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_bomb: got (%0d,%0d) want none", bomb_x, bomb_y);
                end else begin
                    e = b_exp.pop_front();
                    cmp("bomb_x", int'(bomb_x), e.x);
                    cmp("bomb_y", int'(bomb_y), e.y);
                end
            end
        end
        bomb_prev = bomb_req;
        if (st_q.size() != 0) begin
            s = st_q.pop_front();
            if (s.tmo) begin
                checks++; failures++;
                $display("FAIL %s: got timeout want event", s.name);
            end else begin
                cmp({s.name, "_pos_x"}, int'(pos_x), s.px);
                cmp({s.name, "_pos_y"}, int'(pos_y), s.py);
                cmp({s.name, "_moved"}, int'(moved), s.mv);
                cmp({s.name, "_query_valid"}, int'(query_valid), s.qv);
                cmp({s.name, "_bomb_req"}, int'(bomb_req), s.breq);
                if (s.bx >= 0) cmp({s.name, "_bomb_x"}, int'(bomb_x), s.bx);
                if (s.by >= 0) cmp({s.name, "_bomb_y"}, int'(bomb_y), s.by);
                if (s.empty) begin
                    cmp({s.name, "_pending_queries"}, q_exp.size(), 0);
                    cmp({s.name, "_pending_moves"}, m_exp.size(), 0);
                    cmp({s.name, "_pending_bombs"}, b_exp.size(), 0);
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic st(string nm, int px, int py, int mv, int qv, int breq, int bx, int by, bit empty);
        st_t s;
        s.name = nm; s.px = px; s.py = py; s.mv = mv; s.qv = qv;
        s.breq = breq; s.bx = bx; s.by = by; s.empty = empty; s.tmo = 1'b0;
        st_q.push_back(s);
        @(negedge clk);
        #1;
    endtask

    task automatic tmo(string nm);
        st_t s;
        s.name = nm; s.px = 0; s.py = 0; s.mv = 0; s.qv = 0;
        s.breq = 0; s.bx = -1; s.by = -1; s.empty = 1'b0; s.tmo = 1'b1;
        st_q.push_back(s);
        @(negedge clk);
        #1;
    endtask

    task automatic push_q(int x, int y);
        xy_t e; e.x = x; e.y = y; e.gap = 0;
        q_exp.push_back(e);
    endtask

    task automatic push_m(int x, int y, int gap);
        xy_t e; e.x = x; e.y = y; e.gap = gap;
        m_exp.push_back(e);
    endtask

    task automatic push_b(int x, int y);
        xy_t e; e.x = x; e.y = y; e.gap = 0;
        b_exp.push_back(e);
    endtask

    task automatic wait_moves(int n, int lim, string nm);
        int k = 0;
        while (mv_seen < n && k < lim) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (mv_seen < n) tmo(nm);
    endtask

    task automatic wait_queries(int n, int lim, string nm);
        int k = 0;
        while (qv_seen < n && k < lim) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (qv_seen < n) tmo(nm);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        int base;
        int k;
        tick(3);
        st("reset", 1, 1, 0, 0, 0, 0, 0, 1'b1);
        rst = 1'b0;
        tick(2);

        // Hold right: first move after debounce, then repeats 8, 4, 4, ... apart.
        // Release after the 5th move; debounce latency lets one more repeat through.
        push_q(2, 1); push_m(2, 1, 0);
        push_q(3, 1); push_m(3, 1, 8);
        push_q(4, 1); push_m(4, 1, 4);
        push_q(5, 1); push_m(5, 1, 4);
        push_q(6, 1); push_m(6, 1, 4);
        push_q(7, 1); push_m(7, 1, 4);
        base = mv_seen;
        right = 1'b1;
        wait_moves(base + 5, 100, "right_repeat_wait");
        right = 1'b0;
        tick(15);
        st("right_hold", 7, 1, 0, 0, 0, -1, -1, 1'b1);

        // Step to x=0, then left at the left edge: no query, no move.
        do_reset();
        push_q(0, 1); push_m(0, 1, 0);
        base = mv_seen;
        left = 1'b1;
        wait_moves(base + 1, 40, "left_step_wait");
        left = 1'b0;
        tick(10);
        st("left_step", 0, 1, 0, 0, 0, -1, -1, 1'b1);
        left = 1'b1;
        tick(25);
        left = 1'b0;
        tick(8);
        st("left_edge", 0, 1, 0, 0, 0, -1, -1, 1'b1);

        // Up and right together: up wins; wall blocks the move.
        do_reset();
        query_wall = 1'b1;
        push_q(1, 0);
        base = qv_seen;
        up = 1'b1;
        right = 1'b1;
        wait_queries(base + 1, 40, "up_right_wait");
        up = 1'b0;
        right = 1'b0;
        tick(10);
        query_wall = 1'b0;
        st("up_wall", 1, 1, 0, 0, 0, -1, -1, 1'b1);

        // Bomb at (1,1), ack withheld, second press ignored, then ack.
        push_b(1, 1);
        action = 1'b1;
        tick(6);
        action = 1'b0;
        tick(10);
        st("bomb_held", 1, 1, 0, 0, 1, 1, 1, 1'b0);
        action = 1'b1;
        tick(6);
        action = 1'b0;
        tick(10);
        st("bomb_second", 1, 1, 0, 0, 1, 1, 1, 1'b1);
        bomb_ack = 1'b1;
        tick(1);
        bomb_ack = 1'b0;
        st("bomb_ack", 1, 1, 0, 0, 0, -1, -1, 1'b1);
        tick(10);
        st("bomb_idle", 1, 1, 0, 0, 0, -1, -1, 1'b1);

        // Reset while in S_CHECK with a bomb pending.
        push_b(1, 1);
        action = 1'b1;
        tick(6);
        action = 1'b0;
        tick(4);
        push_q(1, 2);
        down = 1'b1;
        k = 0;
        while (!query_valid && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!query_valid) tmo("check_wait");
        rst = 1'b1;
        down = 1'b0;
        tick(1);
        st("rst_in_check", 1, 1, 0, 0, 0, 0, 0, 1'b0);
        rst = 1'b0;
        tick(10);
        st("after_rst", 1, 1, 0, 0, 0, 0, 0, 1'b1);

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bomber_player_ctrl.md
BOMBER_PLAYER_CTRL -- requirements
Module: bomber_player_ctrl

Interface
REQ-001 Parameter GRID_W, default 15, gives the playfield width in cells (x range 0..GRID_W-1).
REQ-002 Parameter GRID_H, default 13, gives the playfield height in cells (y range 0..GRID_H-1).
REQ-003 Parameter START_X / START_Y, defaults 1 / 1, give the player cell after reset.
REQ-004 Parameter DEB_CYCLES, default 4, is the number of consecutive identical samples that makes a key input stable.
REQ-005 Parameter REPEAT_DLY, default 8, is the number of cycles from the first move to the first auto-repeat.
REQ-006 Parameter REPEAT_PER, default 4, is the number of cycles between later auto-repeats.
REQ-007 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-008 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 Ports up, down, left, right, action: inputs, 1 bit each, level key states from the keypad scanner.
REQ-010 Ports query_x / query_y: outputs, 4 bits each, give the cell being checked for a wall.
REQ-011 Port query_valid: output, 1 bit, is high while query_x/query_y are meaningful.
REQ-012 Port query_wall: input, 1 bit, is the combinational map answer for the queried cell in the same cycle.
REQ-013 Ports pos_x / pos_y: outputs, 4 bits each, give the registered player cell.
REQ-014 Port moved: output, 1 bit, pulses for one cycle when the position changes.
REQ-015 Ports bomb_req, input bomb_ack, and outputs bomb_x / bomb_y (4 bits each) form the bomb-placement handshake.

Function
REQ-016 Each key input SHALL have its own debouncer; the stable value SHALL change only after DEB_CYCLES equal raw samples.
REQ-017 The active direction SHALL be chosen from the debounced keys with the fixed priority up > down > left > right.
REQ-018 The target cell SHALL be computed as follows: up y-1, down y+1, left x-1, right x+1.
REQ-019 The state machine SHALL have the states S_IDLE, S_CHECK and S_HOLD.
REQ-020 S_IDLE with a direction active:
  - If the target is inside the grid, the block SHALL go to S_CHECK.
  - If the target is outside the grid (x=0 moving left, x=GRID_W-1 moving right, same rule for y), there SHALL be no query, no move, and the block SHALL go to S_HOLD with the counter set to REPEAT_DLY.
REQ-021 S_CHECK SHALL last exactly one cycle, with query_valid=1 and query_x/query_y set to the target cell.
REQ-022 At the end of S_CHECK with query_wall=0, pos SHALL update to the target and moved SHALL be 1 in the next cycle.
REQ-023 At the end of S_CHECK with query_wall=1, pos SHALL stay unchanged and moved SHALL stay 0.
REQ-024 After S_CHECK the block SHALL always go to S_HOLD.
REQ-025 The hold counter SHALL be loaded on entry to S_HOLD:
  - REPEAT_DLY after the first check of a press;
  - REPEAT_PER after a repeat check.
REQ-026 S_HOLD exit rules:
  - If the active direction is released or changes, the block SHALL return to S_IDLE in the next cycle.
  - If the counter reaches 0 and the direction is unchanged, the block SHALL go to S_CHECK (repeat).
REQ-027 query_valid SHALL be 0 in every state other than S_CHECK.
REQ-028 A rising edge of debounced action while bomb_req=0 SHALL set bomb_req=1 in the next cycle, with bomb_x/bomb_y equal to pos_x/pos_y as registered in the edge cycle.
REQ-029 bomb_req, bomb_x and bomb_y SHALL hold until a cycle in which bomb_ack=1; bomb_req SHALL clear on that edge.
REQ-030 Action edges that occur while bomb_req=1 SHALL be ignored, not queued.
REQ-031 If a move and an action edge occur in the same cycle, the bomb cell SHALL be the pre-move position.
REQ-032 bomb_ack while bomb_req=0 SHALL have no effect.

Reset
REQ-033 rst=1 at a clock edge SHALL set the following, with priority over every other event (including mid-S_CHECK and a pending bomb):
  - pos to START_X/START_Y;
  - state to S_IDLE;
  - moved, bomb_req, bomb_x, bomb_y and query_valid to 0;
  - debouncers to the stable state "released";
  - the hold counter to 0.

Structure
REQ-034 The state encoding and the 4-bit cell-coordinate width SHALL be defined in shared package bomber_pkg.
REQ-035 Debouncing SHALL be a single sub-module, key_debounce, instanced five times.

Verification
REQ-036 Reset, then hold right for 4 cycles with query_wall=0 -> query (2,1); pos becomes (2,1); one moved pulse.
REQ-037 Keep holding right for 20 cycles after the first move -> repeats reach (3,1), then (4,1) and onward, spaced 8 then 4 cycles apart.
REQ-038 Press left at pos (0,y) -> no query_valid; pos unchanged; no moved pulse.
REQ-039 Press up and right together -> up wins; query (1,0); with query_wall=1 pos stays (1,1).
REQ-040 Press action at (1,1) with bomb_ack held low 10 cycles -> bomb_req stays high with bomb_x/bomb_y (1,1); a second press is ignored; ack clears bomb_req next edge.
REQ-041 Assert rst during S_CHECK with bomb_req=1 -> next cycle pos (1,1), bomb_req 0, query_valid 0.
